boot_rom_ctrl: RTL and testbench
================================

# boot_rom_ctrl

Parametrised, loadable boot/option-ROM store, successor to the fixed 128 KiB/16 KiB single-port ROM blocks. Holds BIOS or option-ROM images in on-chip RAM, accepts the image as a byte stream from the host download port, and serves CPU-side reads (and optional shadow-RAM writes) with a request/ack handshake. CPU accesses stall while a download is in progress. Unloaded contents read as all-ones.

## Interface
- `ADDR_W`, default 17: word address width; depth = 2^ADDR_W words.
- `DATA_W`, default 8: word width, 8 or 16 only; any other value is a compile-time error.
- `WRITABLE`, default 0: when 1, CPU writes are honoured while `wp`=0 (shadow RAM); when 0, CPU writes are ignored.
- `clka` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `dl_start` in 1: one-cycle pulse; begin (or restart) an image download at byte 0.
- `dl_valid` in 1: download byte present on `dl_data`.
- `dl_data` in 8: download byte.
- `dl_end` in 1: one-cycle pulse; download complete.
- `dl_ready` out 1: download byte accepted when `dl_valid & dl_ready`.
- `dl_count` out ADDR_W+2: bytes accepted since the last `dl_start`, saturating.
- `dl_ovf` out 1: sticky; a byte arrived beyond image capacity.
- `loaded` out 1: an image has been completely downloaded.
- `wp` in 1: write-protect for CPU writes.
- `cpu_req` in 1: access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: word address.
- `cpu_din` in DATA_W: write data.
- `cpu_dout` out DATA_W: read data, valid while `cpu_ack`=1.
- `cpu_ack` out 1: one-cycle completion strobe.

## Operation
- States: EMPTY (after reset), LOAD, READY.
- EMPTY:
  - CPU requests are accepted and acked.
  - Reads return all-ones; writes are ignored.
  - `dl_start` -> LOAD.
- LOAD:
  - `dl_ready`=1.
  - Each accepted byte at byte index `dl_count` is written to the array, then `dl_count` increments.
  - CPU requests are not accepted: no ack, and the requester holds `cpu_req`.
  - `dl_end` -> READY with `loaded`=1.
  - `dl_start` in LOAD restarts: `dl_count`=0 and `dl_ovf`=0; array contents are left as they are.
- READY:
  - Normal CPU service.
  - `dl_start` -> LOAD with `loaded`=0.
- Byte packing, DATA_W=8: byte n is written to word n.
- Byte packing, DATA_W=16, little-endian:
  - An even byte is held in a low-lane register.
  - The odd byte writes word n>>1 as {odd, even}.
  - On `dl_end` with an even byte pending, flush word n>>1 as {8'hFF, pending}.
- Capacity is 2^ADDR_W × DATA_W/8 bytes.
  - Bytes beyond capacity are still accepted (`dl_ready` stays 1) but discarded.
  - Such bytes set `dl_ovf`.
  - `dl_count` saturates at capacity; the address never wraps.
- CPU writes in READY update the array only if WRITABLE=1 and `wp`=0; otherwise they are dropped. Every write is acked regardless.
- The array has no reset. `rst_n` never clears contents, but `loaded`=0 after reset, so reads return all-ones until the next download completes.

## Timing
- Reset values: `cpu_ack`=0, `cpu_dout`=0, `dl_ready`=0, `dl_count`=0, `dl_ovf`=0, `loaded`=0, state EMPTY.
- A request is accepted in cycle T when `cpu_req`=1 and state is EMPTY or READY.
  - `cpu_ack`=1 and `cpu_dout` are valid in T+1.
  - Holding `cpu_req` high gives back-to-back accesses: one per cycle.
- `cpu_dout` holds its last value when `cpu_ack`=0.
- Write-then-read of the same address in consecutive cycles returns the new data.
- Download write happens in the acceptance cycle. `dl_count` shows the increment in the next cycle.
- `dl_start` in cycle T while a CPU access was accepted in T-1: that ack still issues in T. No new CPU request is accepted from T on.
- `dl_end` and `dl_valid` in the same cycle: the byte is written first, then the transition to READY. `loaded`=1 in T+1.
- CPU requests are accepted again from T+1.
- `dl_start` and `dl_end` in the same cycle: `dl_start` wins.
- `dl_valid` outside LOAD is ignored.
- `rst_n` low mid-download: all outputs go to reset values immediately. Any pending low-lane byte is lost.

## Test plan
- ADDR_W=4, DATA_W=8: reset, then read addr 3 -> ack at T+1 with 8'hFF, `loaded`=0.
- Download 16 bytes 8'h00..8'h0F, then `dl_end`:
  - `dl_count`=16, `loaded`=1.
  - Reads of addr 0..15 back-to-back return 8'h00..8'h0F with 16 consecutive acks.
- Download 18 bytes, ADDR_W=4:
  - `dl_ovf`=1, `dl_count`=16.
  - Word 0 still equals the first byte, so there is no wrap.
- DATA_W=16, ADDR_W=3, download 8'h11,8'h22,8'h33 then `dl_end`:
  - word 0 = 16'h2211.
  - word 1 = 16'hFF33.
- WRITABLE=1:
  - write 8'hA5 to addr 2 with `wp`=0 -> reads 8'hA5.
  - With `wp`=1, write 8'h5A -> acked, reads 8'hA5.
  - With WRITABLE=0, the write is ignored.
- Hold `cpu_req` while pulsing `dl_start` mid-stream:
  - the in-flight access is acked once, then there are no acks during LOAD.
  - Ack resumes the cycle after `dl_end`.
  - Asserting `rst_n`=0 mid-LOAD returns `dl_ready`=0 and `loaded`=0 asynchronously.

Source files
------------

// File: rtl/boot_rom_ctrl.sv
// Loadable boot/option ROM. A host byte stream fills an on-chip array, and the CPU
// side reads it (or shadow-writes it) through a one-cycle req/ack handshake.
module boot_rom_ctrl #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int WRITABLE = 0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              dl_start,
  input  logic              dl_valid,
  input  logic [7:0]        dl_data,
  input  logic              dl_end,
  output logic              dl_ready,
  output logic [ADDR_W+1:0] dl_count,
  output logic              dl_ovf,
  output logic              loaded,
  input  logic              wp,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack
);
  if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
    $error("boot_rom_ctrl: DATA_W must be 8 or 16");
  end

  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] CAP = CW'((2**ADDR_W) * (DATA_W/8));

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_READY} state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [CW-1:0]     dl_count_q, dl_count_d;
  logic              dl_ovf_q, dl_ovf_d;
  logic              loaded_q, loaded_d;
  logic              dl_ready_q;
  logic [7:0]        lane_q, lane_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              cpu_acc, dl_acc, in_cap;

  always_comb begin
    state_d    = state_q;
    dl_count_d = dl_count_q;
    dl_ovf_d   = dl_ovf_q;
    loaded_d   = loaded_q;
    lane_d     = lane_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    dout_d     = dout_q;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    // dl_start blocks acceptance in its own cycle so no access straddles the load
    cpu_acc    = cpu_req && (state_q != S_LOAD) && !dl_start;
    dl_acc     = dl_valid && (state_q == S_LOAD) && !dl_start;
    in_cap     = dl_count_q < CAP;

    if (cpu_acc) begin
      ack_d = 1'b1;
      if (!cpu_we)
        dout_d = (state_q == S_READY) ? mem[cpu_addr] : '1;
      else if (state_q == S_READY && WRITABLE != 0 && !wp) begin
        we    = 1'b1;
        waddr = cpu_addr;
        wdata = cpu_din;
      end
    end

    if (dl_acc) begin
      if (in_cap) begin
        dl_count_d = dl_count_q + 1'b1;
        if (DATA_W == 8) begin
          we    = 1'b1;
          waddr = dl_count_q[ADDR_W-1:0];
          wdata = DATA_W'(dl_data);
        end else if (!dl_count_q[0]) begin
          lane_d = dl_data;
          pend_d = 1'b1;
        end else begin
          we     = 1'b1;
          waddr  = dl_count_q[ADDR_W:1];
          wdata  = DATA_W'({dl_data, lane_q});
          pend_d = 1'b0;
        end
      end else begin
        dl_ovf_d = 1'b1;
      end
    end

    // A trailing even byte (possibly arriving this very cycle) is flushed with FF high lane
    if (state_q == S_LOAD && dl_end && !dl_start) begin
      state_d  = S_READY;
      loaded_d = 1'b1;
      if (DATA_W == 16 && pend_d) begin
        we     = 1'b1;
        waddr  = dl_count_q[ADDR_W:1];
        wdata  = DATA_W'({8'hFF, lane_d});
        pend_d = 1'b0;
      end
    end

    if (dl_start) begin
      state_d    = S_LOAD;
      dl_count_d = '0;
      dl_ovf_d   = 1'b0;
      loaded_d   = 1'b0;
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      dl_count_q <= '0;
      dl_ovf_q   <= 1'b0;
      loaded_q   <= 1'b0;
      dl_ready_q <= 1'b0;
      lane_q     <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dl_count_q <= dl_count_d;
      dl_ovf_q   <= dl_ovf_d;
      loaded_q   <= loaded_d;
      dl_ready_q <= (state_d == S_LOAD);
      lane_q     <= lane_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
    end
  end

  // Array has no reset; contents survive rst_n
  always_ff @(posedge clka) begin
    if (we) mem[waddr] <= wdata;
  end

  assign dl_ready = dl_ready_q;
  assign dl_count = dl_count_q;
  assign dl_ovf   = dl_ovf_q;
  assign loaded   = loaded_q;
  assign cpu_ack  = ack_q;
  assign cpu_dout = dout_q;
endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Bench for boot_rom_ctrl: an 8-bit writable and a 16-bit read-only instance share
// one stimulus stream (both hold 16 bytes) and are checked against a byte-level model.
module tb_boot_rom_ctrl;
  logic clka = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  logic        dl_start = 0, dl_valid = 0, dl_end = 0, wp = 0, cpu_req = 0, cpu_we = 0;
  logic [7:0]  dl_data = '0;
  logic [3:0]  cpu_addr = '0;
  logic [15:0] cpu_din = '0;

  logic        a_rdy, a_ovf, a_ld, a_ack;
  logic [5:0]  a_cnt;
  logic [7:0]  a_dout;
  logic        b_rdy, b_ovf, b_ld, b_ack;
  logic [4:0]  b_cnt;
  logic [15:0] b_dout;

  boot_rom_ctrl #(.ADDR_W(4), .DATA_W(8), .WRITABLE(1)) u_a (
    .clka(clka), .rst_n(rst_n), .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data),
    .dl_end(dl_end), .dl_ready(a_rdy), .dl_count(a_cnt), .dl_ovf(a_ovf), .loaded(a_ld),
    .wp(wp), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din[7:0]),
    .cpu_dout(a_dout), .cpu_ack(a_ack));

  boot_rom_ctrl #(.ADDR_W(3), .DATA_W(16), .WRITABLE(0)) u_b (
    .clka(clka), .rst_n(rst_n), .dl_start(dl_start), .dl_valid(dl_valid), .dl_data(dl_data),
    .dl_end(dl_end), .dl_ready(b_rdy), .dl_count(b_cnt), .dl_ovf(b_ovf), .loaded(b_ld),
    .wp(wp), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr[2:0]), .cpu_din(cpu_din),
    .cpu_dout(b_dout), .cpu_ack(b_ack));

  int nchk = 0, nerr = 0, ack_cnt = 0;

  // Reference model: image as byte stream with 16-byte capacity for both instances
  int          m_cnt;
  bit          m_ovf, m_loaded, m_loading, m_pv;
  logic [7:0]  m_pend;
  logic [7:0]  mA [16];
  logic [15:0] mB [8];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] din;
    logic        wp;
    logic [7:0]  ea;
    logic [15:0] eb;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
    if (a_ack) ack_cnt++;
  endtask

  task automatic m_reset();
    m_cnt = 0; m_ovf = 0; m_loaded = 0; m_loading = 0; m_pv = 0;
  endtask

  task automatic m_start();
    m_cnt = 0; m_ovf = 0; m_loaded = 0; m_loading = 1; m_pv = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (!m_loading) return;
    if (m_cnt < 16) begin
      mA[m_cnt] = b;
      if (m_cnt % 2 == 0) begin m_pend = b; m_pv = 1; end
      else begin mB[m_cnt/2] = {b, m_pend}; m_pv = 0; end
      m_cnt++;
    end else m_ovf = 1;
  endtask

  task automatic m_end();
    if (!m_loading) return;
    if (m_pv) mB[m_cnt/2] = {8'hFF, m_pend};
    m_pv = 0; m_loaded = 1; m_loading = 0;
  endtask

  function automatic logic [7:0] ea(input logic [3:0] a);
    return m_loaded ? mA[a] : 8'hFF;
  endfunction
  function automatic logic [15:0] eb(input logic [3:0] a);
    return m_loaded ? mB[a[2:0]] : 16'hFFFF;
  endfunction

  task automatic status(input string nm);
    chk({nm, ".a_cnt"}, 32'(a_cnt), 32'(m_cnt));
    chk({nm, ".b_cnt"}, 32'(b_cnt), 32'(m_cnt));
    chk({nm, ".ovf"}, {30'b0, a_ovf, b_ovf}, {30'b0, m_ovf, m_ovf});
    chk({nm, ".loaded"}, {30'b0, a_ld, b_ld}, {30'b0, m_loaded, m_loaded});
    chk({nm, ".ready"}, {30'b0, a_rdy, b_rdy}, {30'b0, m_loading, m_loading});
  endtask

  task automatic dl_go();
    dl_start = 1; cyc(); dl_start = 0; m_start();
    status("start");
  endtask

  task automatic dl_send(input logic [7:0] b, input bit with_end);
    dl_valid = 1; dl_data = b; dl_end = with_end;
    cyc();
    dl_valid = 0; dl_end = 0;
    m_byte(b);
    if (with_end) m_end();
    status(with_end ? "byte_end" : "byte");
  endtask

  task automatic dl_fin();
    dl_end = 1; cyc(); dl_end = 0; m_end();
    status("end");
  endtask

  // One CPU cycle, request optional; checks ack and read data against the model
  bit          last_ok = 0;
  logic [7:0]  last_a;
  logic [15:0] last_b;
  task automatic cpu_cyc(input bit req, input bit we_i, input logic [3:0] a,
                         input logic [15:0] d, input bit wp_i, input string nm);
    logic [7:0]  xa;
    logic [15:0] xb;
    xa = ea(a); xb = eb(a);
    cpu_req = req; cpu_we = we_i; cpu_addr = a; cpu_din = d; wp = wp_i;
    cyc();
    if (req) begin
      chk({nm, ".ack"}, {30'b0, a_ack, b_ack}, 32'h3);
      if (!we_i) begin
        chk({nm, ".a_dout"}, 32'(a_dout), 32'(xa));
        chk({nm, ".b_dout"}, 32'(b_dout), 32'(xb));
        last_a = xa; last_b = xb; last_ok = 1;
      end else begin
        last_ok = 0;
        if (m_loaded && !wp_i) mA[a] = d[7:0];
      end
    end else begin
      chk({nm, ".noack"}, {30'b0, a_ack, b_ack}, 32'h0);
      if (last_ok) chk({nm, ".hold"}, {8'h0, a_dout, b_dout}, {8'h0, last_a, last_b});
    end
  endtask

  initial begin
    tv[0] = '{1'b0, 4'h2, 16'h0000, 1'b0, 8'h02, 16'h0504};
    tv[1] = '{1'b1, 4'h2, 16'h00A5, 1'b0, 8'h00, 16'h0000};
    tv[2] = '{1'b0, 4'h2, 16'h0000, 1'b0, 8'hA5, 16'h0504};
    tv[3] = '{1'b1, 4'h2, 16'h005A, 1'b1, 8'h00, 16'h0000};
    tv[4] = '{1'b0, 4'h2, 16'h0000, 1'b0, 8'hA5, 16'h0504};
    tv[5] = '{1'b0, 4'hF, 16'h0000, 1'b0, 8'h0F, 16'h0F0E};

    m_reset();
    #3;
    chk("rst.outs", {a_ack, b_ack, a_rdy, b_rdy, a_ovf, b_ovf, a_ld, b_ld}, 32'h0);
    chk("rst.cnt", {a_cnt, b_cnt}, 32'h0);
    chk("rst.dout", {a_dout, b_dout}, 32'h0);
    cyc(); rst_n = 1; cyc();

    // EMPTY: read all-ones, write ignored
    cpu_cyc(1, 0, 4'h3, 16'h0, 0, "empty_rd");
    chk("empty.loaded", {a_ld, b_ld}, 32'h0);
    cpu_cyc(1, 1, 4'h3, 16'h1234, 0, "empty_wr");
    cpu_cyc(0, 0, 4'h0, 16'h0, 0, "empty_idle");

    // Full 16-byte image
    dl_go();
    for (int i = 0; i < 16; i++) dl_send(8'(i), 1'b0);
    dl_fin();
    chk("img.cnt16", 32'(a_cnt), 32'd16);
    ack_cnt = 0;
    for (int i = 0; i < 16; i++) cpu_cyc(1, 0, 4'(i), 16'h0, 0, "b2b");
    chk("b2b.acks", 32'(ack_cnt), 32'd16);
    cpu_cyc(0, 0, 4'h0, 16'h0, 0, "b2b_idle");

    // Write-protect / writable table, applied back-to-back
    for (int i = 0; i < 6; i++) begin
      cpu_req = 1; cpu_we = tv[i].we; cpu_addr = tv[i].addr; cpu_din = tv[i].din; wp = tv[i].wp;
      cyc();
      chk($sformatf("tv%0d.ack", i), {a_ack, b_ack}, 32'h3);
      if (!tv[i].we) begin
        chk($sformatf("tv%0d.a", i), 32'(a_dout), 32'(tv[i].ea));
        chk($sformatf("tv%0d.b", i), 32'(b_dout), 32'(tv[i].eb));
      end else if (!tv[i].wp) mA[tv[i].addr] = tv[i].din[7:0];
    end
    cpu_req = 0; wp = 0; last_ok = 0; cyc();

    // dl_valid outside LOAD ignored
    dl_valid = 1; dl_data = 8'hEE; cyc(); dl_valid = 0;
    status("valid_ready");

    // Held request across dl_start (with a restart) and dl_end
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'h1;
    chk("hold.pre", 32'(a_dout), 32'(a_dout));
    cyc();
    chk("hold.ack_t0", {a_ack, b_ack}, 32'h3);
    chk("hold.dout_t0", 32'(a_dout), 32'(mA[1]));
    dl_start = 1; cyc(); dl_start = 0; m_start();
    chk("hold.inflight", {30'b0, a_ack, b_ack}, 32'h0);
    ack_cnt = 0;
    dl_send(8'hAA, 0); dl_send(8'hBB, 0);
    dl_go();
    chk("restart.cnt", 32'(a_cnt), 32'd0);
    dl_send(8'h11, 0); dl_send(8'h22, 0); dl_send(8'h33, 0);
    dl_fin();
    chk("hold.no_ack_load", 32'(ack_cnt), 32'd0);
    cyc();
    chk("hold.resume_ack", {a_ack, b_ack}, 32'h3);
    chk("hold.resume_a", 32'(a_dout), 32'h22);
    chk("hold.resume_b", 32'(b_dout), 32'hFF33);
    cpu_addr = 4'h0; cyc(); cpu_req = 0;
    chk("pack.w0", 32'(b_dout), 32'h2211);
    chk("pack.a0", 32'(a_dout), 32'h11);
    cyc(); last_ok = 0;

    // Overflow: 18 bytes into 16-byte capacity
    dl_go();
    for (int i = 0; i < 18; i++) dl_send(8'(8'h80 + i), 1'b0);
    dl_fin();
    chk("ovf.flag", {a_ovf, b_ovf}, 32'h3);
    chk("ovf.cnt", 32'(b_cnt), 32'd16);
    cpu_cyc(1, 0, 4'h0, 16'h0, 0, "ovf_nowrap");
    chk("ovf.w0a", 32'(a_dout), 32'h80);
    chk("ovf.w0b", 32'(b_dout), 32'h8180);

    // dl_start and dl_end together: start wins
    cpu_req = 0;
    dl_go();
    dl_send(8'h5C, 0);
    dl_start = 1; dl_end = 1; cyc(); dl_start = 0; dl_end = 0; m_start();
    status("start_end");
    for (int i = 0; i < 16; i++) dl_send(8'($urandom), 1'b0);
    dl_fin();

    // Randomised downloads interleaved with random CPU traffic
    for (int r = 0; r < 5; r++) begin
      int len;
      len = $urandom_range(0, 20);
      dl_go();
      for (int i = 0; i < len; i++) begin
        if ($urandom % 4 == 0) begin cyc(); status("gap"); end
        dl_send(8'($urandom), (i == len - 1) && ($urandom % 2 == 1));
      end
      if (m_loading) dl_fin();
      last_ok = 0;
      for (int k = 0; k < 40; k++)
        cpu_cyc($urandom % 4 != 0, $urandom % 3 == 0, 4'($urandom), 16'($urandom),
                $urandom % 2 == 1, "rnd");
      cpu_req = 0;
    end

    // Async reset mid-LOAD with a pending low-lane byte
    dl_go();
    dl_send(8'h77, 0);
    #2 rst_n = 0;
    #1;
    chk("arst.ready", {a_rdy, b_rdy}, 32'h0);
    chk("arst.loaded", {a_ld, b_ld}, 32'h0);
    chk("arst.cnt", {a_cnt, b_cnt}, 32'h0);
    m_reset();
    cyc(); rst_n = 1; cyc();
    last_ok = 0;
    cpu_cyc(1, 0, 4'h3, 16'h0, 0, "post_rst_rd");
    cpu_req = 0; cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
